// File: rtl/ex_issue_reg.sv
// ex_issue_reg
//   ID/EX boundary register in front of the EX-stage ALU. Decodes an RV32I
//   instruction into an ALU control code and registered operands, and carries
//   the destination register with a valid/stall/flush handshake.
//
//   Optional build macro: EX_BYPASS_EN
//     defined   -> the previous EX result is forwarded into the rs1/rs2
//                  operands when the held instruction writes that register.
//     undefined -> operands come only from rs1_data/rs2_data.
//
//   Ports
//     clk, rst           clock, synchronous active-high reset
//     in_valid, inst, pc decode-stage instruction, its PC
//     rs1_data, rs2_data register-file read data for inst[19:15]/inst[24:20]
//     stall              hold every register
//     flush              replace the incoming instruction with a bubble
//     ex_result          ALU result of the instruction currently held here
//     in_ready           ~stall
//     out_valid          register holds a live instruction
//     aluin1, aluin2     registered ALU operands
//     aluCtrl            registered ALU operation (ALUCTRL_*)
//     rd_o, we_o         destination register and its write enable
//     illegal_o          unsupported opcode / funct encoding
module ex_issue_reg #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] ex_result,
    output logic            in_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] aluin1,
    output logic [XLEN-1:0] aluin2,
    output logic [3:0]      aluCtrl,
    output logic [4:0]      rd_o,
    output logic            we_o,
    output logic            illegal_o
);

    typedef enum logic [3:0] {
        ALUCTRL_AD   = 4'd0,
        ALUCTRL_SUB  = 4'd1,
        ALUCTRL_SLL  = 4'd2,
        ALUCTRL_SLT  = 4'd3,
        ALUCTRL_SLTU = 4'd4,
        ALUCTRL_XOR  = 4'd5,
        ALUCTRL_SRL  = 4'd6,
        ALUCTRL_SRA  = 4'd7,
        ALUCTRL_OR   = 4'd8,
        ALUCTRL_AND  = 4'd9
    } alu_ctrl_e;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OPIMM  = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    // Registered state
    logic            valid_q;
    logic [31:0]     a1_q, a2_q;
    alu_ctrl_e       ctrl_q;
    logic [4:0]      rd_q;
    logic            we_q, ill_q;

    // Decoded next values for a live instruction
    logic [31:0]     a1_d, a2_d;
    alu_ctrl_e       ctrl_d;
    logic [4:0]      rd_d;
    logic            we_d, ill_d;

    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
    logic [31:0] op1, op2;

    assign funct7 = inst[31:25];
    assign funct3 = inst[14:12];
    assign rd_f   = inst[11:7];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign shamt = {27'b0, inst[24:20]};

`ifdef EX_BYPASS_EN
    // Forward only from a live, register-writing instruction; we_q already
    // implies rd_q != 0, the explicit test keeps x0 out regardless.
    logic byp1, byp2;
    assign byp1 = valid_q && we_q && (rd_q != 5'd0) && (rd_q == inst[19:15]);
    assign byp2 = valid_q && we_q && (rd_q != 5'd0) && (rd_q == inst[24:20]);
    assign op1  = byp1 ? ex_result : rs1_data;
    assign op2  = byp2 ? ex_result : rs2_data;
`else
    logic unused_ex_result;
    assign unused_ex_result = ^ex_result;
    assign op1 = rs1_data;
    assign op2 = rs2_data;
`endif

    always_comb begin
        a1_d   = '0;
        a2_d   = '0;
        ctrl_d = ALUCTRL_AD;
        rd_d   = rd_f;
        we_d   = 1'b0;
        ill_d  = 1'b0;
        case (inst[6:0])
            OPC_OP: begin
                a1_d = op1;
                a2_d = op2;
                we_d = 1'b1;
                if (funct7 != 7'b0000000 && funct7 != 7'b0100000)
                    ill_d = 1'b1;
                case (funct3)
                    3'b000: ctrl_d = inst[30] ? ALUCTRL_SUB : ALUCTRL_AD;
                    3'b001: begin
                        ctrl_d = ALUCTRL_SLL;
                        a2_d   = {27'b0, op2[4:0]};
                    end
                    3'b010: ctrl_d = ALUCTRL_SLT;
                    3'b011: ctrl_d = ALUCTRL_SLTU;
                    3'b100: ctrl_d = ALUCTRL_XOR;
                    3'b101: begin
                        ctrl_d = inst[30] ? ALUCTRL_SRA : ALUCTRL_SRL;
                        a2_d   = {27'b0, op2[4:0]};
                    end
                    3'b110: ctrl_d = ALUCTRL_OR;
                    default: ctrl_d = ALUCTRL_AND;
                endcase
            end
            OPC_OPIMM: begin
                a1_d = op1;
                a2_d = imm_i;
                we_d = 1'b1;
                case (funct3)
                    3'b000: ctrl_d = ALUCTRL_AD;
                    3'b001: begin
                        ctrl_d = ALUCTRL_SLL;
                        a2_d   = shamt;
                        if (funct7 != 7'b0000000) ill_d = 1'b1;
                    end
                    3'b010: ctrl_d = ALUCTRL_SLT;
                    3'b011: ctrl_d = ALUCTRL_SLTU;
                    3'b100: ctrl_d = ALUCTRL_XOR;
                    3'b101: begin
                        a2_d = shamt;
                        if (funct7 == 7'b0000000)      ctrl_d = ALUCTRL_SRL;
                        else if (funct7 == 7'b0100000) ctrl_d = ALUCTRL_SRA;
                        else                           ill_d  = 1'b1;
                    end
                    3'b110: ctrl_d = ALUCTRL_OR;
                    default: ctrl_d = ALUCTRL_AND;
                endcase
            end
            OPC_LOAD: begin
                a1_d = op1;
                a2_d = imm_i;
                we_d = 1'b1;
            end
            OPC_STORE: begin
                a1_d = op1;
                a2_d = imm_s;
            end
            OPC_BRANCH: begin
                a1_d = pc;
                a2_d = imm_b;
            end
            OPC_JAL: begin
                a1_d = pc;
                a2_d = imm_j;
                we_d = 1'b1;
            end
            OPC_JALR: begin
                a1_d = op1;
                a2_d = imm_i;
                we_d = 1'b1;
            end
            OPC_LUI: begin
                a2_d = imm_u;
                we_d = 1'b1;
            end
            OPC_AUIPC: begin
                a1_d = pc;
                a2_d = imm_u;
                we_d = 1'b1;
            end
            default: ill_d = 1'b1;
        endcase

        // An illegal instruction still flows through as valid but must not
        // write back or drive a meaningful operation.
        if (ill_d) begin
            a1_d   = '0;
            a2_d   = '0;
            ctrl_d = ALUCTRL_AD;
            rd_d   = 5'd0;
            we_d   = 1'b0;
        end else if (rd_f == 5'd0) begin
            we_d = 1'b0;
        end
    end

    // Reset, flush and an idle (unstalled, invalid) input all load the same
    // bubble; flush wins over stall.
    always_ff @(posedge clk) begin
        if (rst || flush || (!stall && !in_valid)) begin
            valid_q <= 1'b0;
            a1_q    <= '0;
            a2_q    <= '0;
            ctrl_q  <= ALUCTRL_AD;
            rd_q    <= 5'd0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else if (!stall) begin
            valid_q <= 1'b1;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            ill_q   <= ill_d;
        end
    end

    assign in_ready  = ~stall;
    assign out_valid = valid_q;
    assign aluin1    = a1_q;
    assign aluin2    = a2_q;
    assign aluCtrl   = ctrl_q;
    assign rd_o      = rd_q;
    assign we_o      = we_q;
    assign illegal_o = ill_q;

endmodule

// File: tb/tb_ex_issue_reg.sv
// tb_ex_issue_reg
//   Directed bench for ex_issue_reg. Each task drives its own vectors and
//   compares the packed output bundle against hand-computed values.
//   Compile with +define+EX_BYPASS_EN to exercise the forwarding build.
module tb_ex_issue_reg;

    localparam logic [3:0] C_AD   = 4'd0;
    localparam logic [3:0] C_SUB  = 4'd1;
    localparam logic [3:0] C_SLL  = 4'd2;
    localparam logic [3:0] C_SLT  = 4'd3;
    localparam logic [3:0] C_SLTU = 4'd4;
    localparam logic [3:0] C_XOR  = 4'd5;
    localparam logic [3:0] C_SRL  = 4'd6;
    localparam logic [3:0] C_SRA  = 4'd7;
    localparam logic [3:0] C_OR   = 4'd8;
    localparam logic [3:0] C_AND  = 4'd9;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush;
    logic [31:0] inst, pc, rs1_data, rs2_data, ex_result;
    logic        in_ready, out_valid, we_o, illegal_o;
    logic [31:0] aluin1, aluin2;
    logic [3:0]  aluCtrl;
    logic [4:0]  rd_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // {out_valid, aluin1, aluin2, aluCtrl, rd_o, we_o, illegal_o}
    logic [75:0] obs;
    assign obs = {out_valid, aluin1, aluin2, aluCtrl, rd_o, we_o, illegal_o};

    always #5 clk = ~clk;

    ex_issue_reg #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .inst(inst), .pc(pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .stall(stall), .flush(flush),
        .ex_result(ex_result), .in_ready(in_ready), .out_valid(out_valid),
        .aluin1(aluin1), .aluin2(aluin2), .aluCtrl(aluCtrl), .rd_o(rd_o),
        .we_o(we_o), .illegal_o(illegal_o)
    );

    function automatic logic [75:0] pk(input logic v, input logic [31:0] a1,
                                       input logic [31:0] a2, input logic [3:0] c,
                                       input logic [4:0] rd, input logic we,
                                       input logic ill);
        return {v, a1, a2, c, rd, we, ill};
    endfunction

    localparam logic [75:0] BUBBLE = {1'b0, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0};
    localparam logic [75:0] M_ALL  = {76{1'b1}};
    localparam logic [75:0] M_NORD = ~{69'h0, 5'h1F, 2'b00};

    // Apply one set of inputs, clock once, sample 1 time unit after the edge.
    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] ex, input logic v,
                         input logic st, input logic fl);
        inst = i; pc = p; rs1_data = r1; rs2_data = r2; ex_result = ex;
        in_valid = v; stall = st; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        logic [75:0] e;
        rst = 1'b1;
        drive(32'h00500093, 32'h40, 32'h7, 32'h9, 32'h3, 1'b1, 1'b0, 1'b0);
        drive(32'h00500093, 32'h40, 32'h7, 32'h9, 32'h3, 1'b1, 1'b0, 1'b0);
        e = BUBBLE;
        total_cnt++;
        if (obs !== e) $display("FAIL reset_values got %h exp %h", obs, e);
        else pass_cnt++;
        stall = 1'b1; #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL in_ready_stall got %b exp 0", in_ready);
        else pass_cnt++;
        stall = 1'b0; #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL in_ready_run got %b exp 1", in_ready);
        else pass_cnt++;
        rst = 1'b0;
        bubble();
        total_cnt++;
        if (obs !== e) $display("FAIL reset_release_idle got %h exp %h", obs, e);
        else pass_cnt++;
    endtask

    task automatic test_addi();
        logic [75:0] e;
        drive(32'h00500093, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        e = pk(1'b1, 32'h0, 32'h5, C_AD, 5'd1, 1'b1, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL addi got %h exp %h", obs, e);
        else pass_cnt++;
        bubble();
        drive(32'h00500093, 32'h0, 32'hFFFFFFF0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        e = pk(1'b1, 32'hFFFFFFF0, 32'h5, C_AD, 5'd1, 1'b1, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL addi_neg_rs1 got %h exp %h", obs, e);
        else pass_cnt++;
    endtask

    task automatic test_sub_shift();
        logic [75:0] e;
        bubble();
        drive(32'h402081B3, 32'h0, 32'd10, 32'd3, 32'h0, 1'b1, 1'b0, 1'b0);
        e = pk(1'b1, 32'd10, 32'd3, C_SUB, 5'd3, 1'b1, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL sub got %h exp %h", obs, e);
        else pass_cnt++;
        bubble();
        drive(32'h4030D293, 32'h0, 32'h80000000, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        e = pk(1'b1, 32'h80000000, 32'd3, C_SRA, 5'd5, 1'b1, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL srai got %h exp %h", obs, e);
        else pass_cnt++;
        bubble();
        drive(32'h0020D1B3, 32'h0, 32'h12345678, 32'hFFFFFFE4, 32'h0, 1'b1, 1'b0, 1'b0);
        e = pk(1'b1, 32'h12345678, 32'd4, C_SRL, 5'd3, 1'b1, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL srl_mask got %h exp %h", obs, e);
        else pass_cnt++;
    endtask

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs2;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        we;
        logic        chk_rd;
    } vec_t;

    task automatic test_decode_table();
        vec_t v [17];
        logic [75:0] e, m;
        v[0]  = '{32'h123452B7, 32'h0,   32'h0,        32'h0,        32'h12345000, C_AD,   5'd5,  1'b1, 1'b1};
        v[1]  = '{32'hFFFFF317, 32'h100, 32'h0,        32'h100,      32'hFFFFF000, C_AD,   5'd6,  1'b1, 1'b1};
        v[2]  = '{32'hFE20AE23, 32'h0,   32'h0,        32'h11111111, 32'hFFFFFFFC, C_AD,   5'd0,  1'b0, 1'b0};
        v[3]  = '{32'hFE208CE3, 32'h200, 32'h0,        32'h200,      32'hFFFFFFF8, C_AD,   5'd0,  1'b0, 1'b0};
        v[4]  = '{32'h001000EF, 32'h300, 32'h0,        32'h300,      32'h00000800, C_AD,   5'd1,  1'b1, 1'b1};
        v[5]  = '{32'h00408067, 32'h0,   32'h0,        32'h11111111, 32'h4,        C_AD,   5'd0,  1'b0, 1'b1};
        v[6]  = '{32'hFFF12383, 32'h0,   32'h0,        32'h11111111, 32'hFFFFFFFF, C_AD,   5'd7,  1'b1, 1'b1};
        v[7]  = '{32'h0030B213, 32'h0,   32'h0,        32'h11111111, 32'h3,        C_SLTU, 5'd4,  1'b1, 1'b1};
        v[8]  = '{32'h0020C433, 32'h0,   32'h0F0F0F0F, 32'h11111111, 32'h0F0F0F0F, C_XOR,  5'd8,  1'b1, 1'b1};
        v[9]  = '{32'h0020F4B3, 32'h0,   32'hA5,       32'h11111111, 32'hA5,       C_AND,  5'd9,  1'b1, 1'b1};
        v[10] = '{32'h01F09513, 32'h0,   32'h0,        32'h11111111, 32'd31,       C_SLL,  5'd10, 1'b1, 1'b1};
        v[11] = '{32'h0020E5B3, 32'h0,   32'h1234,     32'h11111111, 32'h1234,     C_OR,   5'd11, 1'b1, 1'b1};
        v[12] = '{32'h0020A633, 32'h0,   32'h5,        32'h11111111, 32'h5,        C_SLT,  5'd12, 1'b1, 1'b1};
        v[13] = '{32'h002096B3, 32'h0,   32'hFFFFFFFF, 32'h11111111, 32'd31,       C_SLL,  5'd13, 1'b1, 1'b1};
        v[14] = '{32'h4020D733, 32'h0,   32'h25,       32'h11111111, 32'd5,        C_SRA,  5'd14, 1'b1, 1'b1};
        v[15] = '{32'hFFE0C793, 32'h0,   32'h0,        32'h11111111, 32'hFFFFFFFE, C_XOR,  5'd15, 1'b1, 1'b1};
        v[16] = '{32'h0070D813, 32'h0,   32'h0,        32'h11111111, 32'd7,        C_SRL,  5'd16, 1'b1, 1'b1};
        for (int k = 0; k < 17; k++) begin
            bubble();
            drive(v[k].inst, v[k].pc, 32'h11111111, v[k].rs2, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
            e = pk(1'b1, v[k].a1, v[k].a2, v[k].ctrl, v[k].rd, v[k].we, 1'b0);
            m = v[k].chk_rd ? M_ALL : M_NORD;
            total_cnt++;
            if ((obs & m) !== (e & m))
                $display("FAIL decode[%0d] inst %h got %h exp %h", k, v[k].inst, obs & m, e & m);
            else pass_cnt++;
        end
    endtask

    task automatic test_bypass();
        logic [75:0] e;
        bubble();
        drive(32'h00500093, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        drive(32'h00108133, 32'h0, 32'h0, 32'h0, 32'h5, 1'b1, 1'b0, 1'b0);
`ifdef EX_BYPASS_EN
        e = pk(1'b1, 32'h5, 32'h5, C_AD, 5'd2, 1'b1, 1'b0);
`else
        e = pk(1'b1, 32'h0, 32'h0, C_AD, 5'd2, 1'b1, 1'b0);
`endif
        total_cnt++;
        if (obs !== e) $display("FAIL bypass_add got %h exp %h", obs, e);
        else pass_cnt++;
        // x2 is held now; SLL x3,x1,x2 forwards only rs2, then masks it.
        drive(32'h002091B3, 32'h0, 32'h7, 32'h10, 32'hFFFFFFE3, 1'b1, 1'b0, 1'b0);
`ifdef EX_BYPASS_EN
        e = pk(1'b1, 32'h7, 32'h3, C_SLL, 5'd3, 1'b1, 1'b0);
`else
        e = pk(1'b1, 32'h7, 32'h10, C_SLL, 5'd3, 1'b1, 1'b0);
`endif
        total_cnt++;
        if (obs !== e) $display("FAIL bypass_shift_mask got %h exp %h", obs, e);
        else pass_cnt++;
        // Previous slot was a bubble: no forwarding even though rd matches field.
        bubble();
        drive(32'h00108133, 32'h0, 32'h9, 32'hA, 32'h5, 1'b1, 1'b0, 1'b0);
        e = pk(1'b1, 32'h9, 32'hA, C_AD, 5'd2, 1'b1, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL bypass_after_bubble got %h exp %h", obs, e);
        else pass_cnt++;
    endtask

    task automatic test_stall_flush();
        logic [75:0] e;
        bubble();
        drive(32'h00500093, 32'h0, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        e = pk(1'b1, 32'h100, 32'h5, C_AD, 5'd1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(32'h402081B3 + k, 32'h44, 32'h55 + k, 32'h66, 32'h77 + k, 1'b1, 1'b1, 1'b0);
            total_cnt++;
            if (obs !== e) $display("FAIL stall_hold[%0d] got %h exp %h", k, obs, e);
            else pass_cnt++;
        end
        drive(32'h402081B3, 32'h0, 32'h1, 32'h1, 32'h0, 1'b1, 1'b1, 1'b1);
        total_cnt++;
        if (obs !== BUBBLE) $display("FAIL flush_with_stall got %h exp %h", obs, BUBBLE);
        else pass_cnt++;
        drive(32'h00500093, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        drive(32'h402081B3, 32'h0, 32'h1, 32'h1, 32'h0, 1'b1, 1'b0, 1'b1);
        total_cnt++;
        if (obs !== BUBBLE) $display("FAIL flush got %h exp %h", obs, BUBBLE);
        else pass_cnt++;
        // Stall with in_valid low must still hold the live instruction.
        drive(32'h00500093, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        drive(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        e = pk(1'b1, 32'h0, 32'h5, C_AD, 5'd1, 1'b1, 1'b0);
        total_cnt++;
        if (obs !== e) $display("FAIL stall_invalid_hold got %h exp %h", obs, e);
        else pass_cnt++;
        // Reset wins over a simultaneous stall.
        rst = 1'b1;
        drive(32'h402081B3, 32'h0, 32'h1, 32'h1, 32'h0, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        total_cnt++;
        if (obs !== BUBBLE) $display("FAIL reset_over_stall got %h exp %h", obs, BUBBLE);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        logic [31:0] bad [4];
        logic [75:0] e, m;
        bad[0] = 32'hFFFFFFFF;
        bad[1] = 32'h02208133;
        bad[2] = 32'h0230D293;
        bad[3] = 32'h40109093;
        m = pk(1'b1, 32'h0, 32'h0, 4'hF, 5'd0, 1'b1, 1'b1);
        e = pk(1'b1, 32'h0, 32'h0, C_AD, 5'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            bubble();
            drive(bad[k], 32'h0, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0);
            total_cnt++;
            if ((obs & m) !== e)
                $display("FAIL illegal[%0d] inst %h got %h exp %h", k, bad[k], obs & m, e);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        inst = '0; pc = '0; rs1_data = '0; rs2_data = '0; ex_result = '0;
        test_reset();
        test_addi();
        test_sub_shift();
        test_decode_table();
        test_bypass();
        test_stall_flush();
        test_illegal();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
